// File: rtl/ip_rx_chksum_feed.sv
// ip_rx_chksum_feed: forks RX IP packets into a checksum command, a header-only checksum stream and a full forward stream
module ip_rx_chksum_feed #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic [KEEP_WIDTH-1:0] src_keep,
  input  logic                  src_val,
  input  logic                  src_last,
  output logic                  src_rdy,
  output logic                  chksum_cmd_val,
  output logic                  chksum_cmd_enable,
  output logic [7:0]            chksum_cmd_start,
  output logic [7:0]            chksum_cmd_offset,
  output logic [15:0]           chksum_cmd_init,
  input  logic                  chksum_cmd_rdy,
  output logic [DATA_WIDTH-1:0] chksum_req_data,
  output logic [KEEP_WIDTH-1:0] chksum_req_keep,
  output logic                  chksum_req_val,
  output logic                  chksum_req_last,
  input  logic                  chksum_req_rdy,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [KEEP_WIDTH-1:0] fwd_keep,
  output logic                  fwd_last,
  output logic                  fwd_val,
  input  logic                  fwd_rdy
);
  typedef enum logic [1:0] {HDR_FIRST, HDR_REST, TAIL} state_t;
  localparam logic [15:0] KW16 = 16'(KEEP_WIDTH);
  state_t state_q, state_d;
  logic [15:0] hdr_rem_q, hdr_rem_d;
  logic cmd_done_q, cmd_done_d, req_done_q, req_done_d, fwd_done_q, fwd_done_d;
  logic [3:0] ihl;
  logic [15:0] hdr_len, cur, n;
  logic first, in_hdr, fire;
  assign chksum_cmd_enable = 1'b1;
  assign chksum_cmd_start  = 8'd0;
  assign chksum_cmd_offset = 8'd10;
  assign chksum_cmd_init   = 16'd0;
  assign chksum_req_data   = src_data;
  assign fwd_data          = src_data;
  assign fwd_keep          = src_keep;
  assign fwd_last          = src_last;
  // cur is the header byte count still owed as of this beat; zero in TAIL
  always_comb begin
    ihl = src_data[DATA_WIDTH-5 -: 4];
    hdr_len = {10'd0, (ihl < 4'd5) ? 4'd5 : ihl, 2'b00};
    first = state_q == HDR_FIRST;
    in_hdr = state_q != TAIL;
    cur = first ? hdr_len : hdr_rem_q;
    n = (cur > KW16) ? KW16 : cur;
    chksum_req_keep = src_keep & ~({KEEP_WIDTH{1'b1}} >> n);
    chksum_req_last = src_last | (cur <= KW16);
    chksum_cmd_val = !rst & src_val & first & !cmd_done_q;
    chksum_req_val = !rst & src_val & in_hdr & !req_done_q;
    fwd_val = !rst & src_val & !fwd_done_q;
    src_rdy = !rst & (!first | cmd_done_q | chksum_cmd_rdy)
                   & (!in_hdr | req_done_q | chksum_req_rdy)
                   & (fwd_done_q | fwd_rdy);
    fire = src_val & src_rdy;
    cmd_done_d = !fire & (cmd_done_q | (chksum_cmd_val & chksum_cmd_rdy));
    req_done_d = !fire & (req_done_q | (chksum_req_val & chksum_req_rdy));
    fwd_done_d = !fire & (fwd_done_q | (fwd_val & fwd_rdy));
    state_d = !fire ? state_q : src_last ? HDR_FIRST : chksum_req_last ? TAIL : HDR_REST;
    hdr_rem_d = !fire ? hdr_rem_q : (state_d == HDR_REST) ? cur - KW16 : 16'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR_FIRST;
      hdr_rem_q <= '0;
      cmd_done_q <= 1'b0;
      req_done_q <= 1'b0;
      fwd_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_rem_q <= hdr_rem_d;
      cmd_done_q <= cmd_done_d;
      req_done_q <= req_done_d;
      fwd_done_q <= fwd_done_d;
    end
  end
endmodule
